// File: rtl/cobra_core.sv
// cobra_core: multi-cycle FETCH/LOAD/EXEC processor with a register file, ALU,
// signed relative jumps/branches, handshaked input/output ports and a halt state.
module cobra_core #(
  parameter int XLEN    = 32,
  parameter int REGS    = 32,
  parameter int IMEM_AW = 8,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               retire,
  output logic               halted
);

  localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_EXEC, S_HALT} state_t;

  state_t             state;
  logic [IMEM_AW-1:0] pc;
  logic [31:0]        ir;
  logic [XLEN-1:0]    regs [REGS];

  // Instruction fields of the held instruction
  logic          f_j, f_b, f_we;
  logic [1:0]    f_ws;
  logic [3:0]    f_op;
  logic [IW-1:0] f_ra1, f_ra2, f_wa;
  logic [7:0]    f_off;

  assign f_j   = ir[31];
  assign f_b   = ir[30];
  assign f_we  = ir[29];
  assign f_ws  = ir[28:27];
  assign f_op  = ir[26:23];
  assign f_ra1 = ir[18 +: IW];
  assign f_ra2 = ir[13 +: IW];
  assign f_wa  = ir[8 +: IW];
  assign f_off = ir[7:0];

  // Register 0 is never written, so plain reads return zero for it
  logic [XLEN-1:0] rd1, rd2, ld_rd1;
  assign rd1    = regs[f_ra1];
  assign rd2    = regs[f_ra2];
  // Operand for an OUT instruction, read while the instruction is being loaded
  assign ld_rd1 = regs[imem_rdata[18 +: IW]];

  logic [SW-1:0] shamt;
  assign shamt = rd2[SW-1:0];

  logic [XLEN-1:0] arith, alu_res;
  logic            alu_flag;

  // ALU: arithmetic/logic result for ops 0-7, comparison flag for ops 8-F
  always_comb begin
    arith    = '0;
    alu_flag = 1'b0;
    case (f_op)
      4'h0: arith = rd1 + rd2;
      4'h1: arith = rd1 - rd2;
      4'h2: arith = rd1 << shamt;
      4'h3: arith = rd1 >> shamt;
      4'h4: arith = $unsigned($signed(rd1) >>> shamt);
      4'h5: arith = rd1 ^ rd2;
      4'h6: arith = rd1 | rd2;
      4'h7: arith = rd1 & rd2;
      4'h8: alu_flag = (rd1 == rd2);
      4'h9: alu_flag = (rd1 != rd2);
      4'hA: alu_flag = ($signed(rd1) <  $signed(rd2));
      4'hB: alu_flag = ($signed(rd1) >= $signed(rd2));
      4'hC: alu_flag = (rd1 <  rd2);
      4'hD: alu_flag = (rd1 >= rd2);
      4'hE: alu_flag = ($signed(rd1) <  $signed(rd2));
      4'hF: alu_flag = (rd1 <  rd2);
      default: arith = '0;
    endcase
  end

  assign alu_res = f_op[3] ? XLEN'(alu_flag) : arith;

  // Write-back value selection
  logic [XLEN-1:0] wdata;
  // Choose constant, input word or ALU result as the register write value
  always_comb begin
    case (f_ws)
      2'b00:   wdata = XLEN'(signed'(f_off));
      2'b01:   wdata = XLEN'(in_data);
      2'b10:   wdata = alu_res;
      default: wdata = '0;
    endcase
  end

  // Next pc and halt detection
  logic [31:0]        off_ext;
  logic               taken;
  logic [IMEM_AW-1:0] pc_next;
  logic               halt_next;

  assign off_ext   = 32'(signed'(f_off));
  assign taken     = f_j | (f_b & alu_flag);
  assign pc_next   = taken ? (pc + off_ext[IMEM_AW-1:0]) : (pc + IMEM_AW'(1));
  assign halt_next = taken && (f_off == 8'h00);

  logic can_retire;
  // EXEC completes when its handshake (if any) happens this cycle
  always_comb begin
    case (f_ws)
      2'b01:   can_retire = in_valid;
      2'b11:   can_retire = out_ready;
      default: can_retire = 1'b1;
    endcase
  end

  // Retire must coincide with the handshake cycle, so it follows the inputs
  assign retire = (state == S_EXEC) && can_retire;

  // Control FSM, register file, pc and registered port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= 32'h0000_0000;
      imem_addr <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          ir        <= imem_rdata;
          in_ready  <= (imem_rdata[28:27] == 2'b01);
          out_valid <= (imem_rdata[28:27] == 2'b11);
          out_data  <= (imem_rdata[28:27] == 2'b11) ? ld_rd1[OUT_W-1:0] : '0;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (can_retire) begin
            if (f_we && (f_ws != 2'b11) && (f_wa != '0)) begin
              regs[f_wa] <= wdata;
            end
            pc        <= pc_next;
            imem_addr <= pc_next;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            if (halt_next) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state  <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cobra_core.sv
// Self-checking bench for cobra_core: directed programs in a modelled IMEM,
// expected output words queued up front and checked by a separate monitor.
module tb_cobra_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        retire;
  logic        halted;

  cobra_core dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the next queued word and retire
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %h expected no transfer", out_data);
      end else begin
        check("out_data", {16'h0000, out_data}, {16'h0000, exp_q.pop_front()});
        check("out_retire", {31'd0, retire}, 32'd1);
      end
    end
  end

  function automatic logic [31:0] enc(input logic j, input logic b, input logic we,
                                      input logic [1:0] ws, input logic [3:0] op,
                                      input logic [4:0] ra1, input logic [4:0] ra2,
                                      input logic [4:0] wa, input logic [7:0] off);
    return {j, b, we, ws, op, ra1, ra2, wa, off};
  endfunction
  function automatic logic [31:0] i_const(input logic [4:0] wa, input logic [7:0] c);
    return enc(1'b0, 1'b0, 1'b1, 2'b00, 4'h0, 5'd0, 5'd0, wa, c);
  endfunction
  function automatic logic [31:0] i_in(input logic [4:0] wa);
    return enc(1'b0, 1'b0, 1'b1, 2'b01, 4'h0, 5'd0, 5'd0, wa, 8'h00);
  endfunction
  function automatic logic [31:0] i_alu(input logic [3:0] op, input logic [4:0] wa,
                                        input logic [4:0] a, input logic [4:0] b);
    return enc(1'b0, 1'b0, 1'b1, 2'b10, op, a, b, wa, 8'h00);
  endfunction
  function automatic logic [31:0] i_out(input logic [4:0] a);
    return enc(1'b0, 1'b0, 1'b0, 2'b11, 4'h0, a, 5'd0, 5'd0, 8'h00);
  endfunction
  function automatic logic [31:0] i_jmp(input logic [7:0] off);
    return enc(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, off);
  endfunction
  function automatic logic [31:0] i_br(input logic [3:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [7:0] off);
    return enc(1'b0, 1'b1, 1'b0, 2'b10, op, a, b, 5'd0, off);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = i_jmp(8'h00);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      #1;
      if (halted) break;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    // ---- Test 1: constants, ADD, OUT, halt with exact cycle timing ----
    clear_mem();
    mem[0] = i_const(5'd1, 8'd5);
    mem[1] = i_const(5'd2, 8'hFD);
    mem[2] = i_alu(4'h0, 5'd3, 5'd1, 5'd2);
    mem[3] = i_out(5'd3);
    mem[4] = i_jmp(8'h00);
    out_ready = 1'b1;
    hold_reset();
    #1;
    check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    exp_q.push_back(16'h0002);
    @(negedge clk);
    release_reset();
    for (int s = 1; s <= 18; s++) begin
      @(negedge clk);
      #1;
      check("t1_retire", {31'd0, retire}, {31'd0, ((s % 3) == 2) && (s <= 14)});
      check("t1_halted", {31'd0, halted}, {31'd0, (s >= 15)});
      check("t1_out_valid", {31'd0, out_valid}, {31'd0, (s == 11)});
    end
    check("t1_imem_addr", {24'd0, imem_addr}, 32'd4);

    // ---- Test 2: counted loop with BNE back-branch ----
    hold_reset();
    clear_mem();
    mem[0] = i_const(5'd1, 8'd0);
    mem[1] = i_const(5'd2, 8'd5);
    mem[2] = i_const(5'd3, 8'd1);
    mem[3] = i_out(5'd1);
    mem[4] = i_alu(4'h0, 5'd1, 5'd1, 5'd3);
    mem[5] = i_br(4'h9, 5'd1, 5'd2, 8'hFE);
    mem[6] = i_jmp(8'h00);
    for (int v = 0; v < 5; v++) exp_q.push_back(16'(v));
    release_reset();
    wait_halt("t2", 200);
    check("t2_imem_addr", {24'd0, imem_addr}, 32'd6);

    // ---- Test 3: input stall then transfer, zero extension checked ----
    hold_reset();
    clear_mem();
    mem[0] = i_in(5'd4);
    mem[1] = i_out(5'd4);
    mem[2] = i_const(5'd6, 8'd16);
    mem[3] = i_alu(4'h3, 5'd5, 5'd4, 5'd6);
    mem[4] = i_out(5'd5);
    mem[5] = i_jmp(8'h00);
    in_valid = 1'b0;
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h0000);
    release_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      #1;
      check("t3_in_ready", {31'd0, in_ready}, 32'd1);
      check("t3_no_retire", {31'd0, retire}, 32'd0);
      check("t3_pc_hold", {24'd0, imem_addr}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = 16'hABCD;
    #1;
    check("t3_retire", {31'd0, retire}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 16'h0000;
    #1;
    check("t3_in_ready_drop", {31'd0, in_ready}, 32'd0);
    check("t3_pc_adv", {24'd0, imem_addr}, 32'd1);
    wait_halt("t3", 100);

    // ---- Test 4: output back-pressure ----
    hold_reset();
    clear_mem();
    mem[0] = i_const(5'd1, 8'h5A);
    mem[1] = i_out(5'd1);
    mem[2] = i_jmp(8'h00);
    out_ready = 1'b0;
    exp_q.push_back(16'h005A);
    release_reset();
    repeat (5) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t4_out_valid", {31'd0, out_valid}, 32'd1);
      check("t4_out_data", {16'd0, out_data}, 32'h005A);
      check("t4_no_retire", {31'd0, retire}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("t4_retire", {31'd0, retire}, 32'd1);
    @(negedge clk);
    #1;
    check("t4_out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t4_out_data_zero", {16'd0, out_data}, 32'd0);
    wait_halt("t4", 50);

    // ---- Test 5: x0, shifts, compares, SUB, XOR ----
    hold_reset();
    clear_mem();
    mem[0]  = i_const(5'd0, 8'd7);
    mem[1]  = i_out(5'd0);
    mem[2]  = i_const(5'd1, 8'd1);
    mem[3]  = i_const(5'd2, 8'd31);
    mem[4]  = i_alu(4'h2, 5'd3, 5'd1, 5'd2);
    mem[5]  = i_const(5'd4, 8'd4);
    mem[6]  = i_alu(4'h4, 5'd5, 5'd3, 5'd4);
    mem[7]  = i_alu(4'h3, 5'd6, 5'd3, 5'd4);
    mem[8]  = i_const(5'd7, 8'd16);
    mem[9]  = i_alu(4'h3, 5'd8, 5'd5, 5'd7);
    mem[10] = i_out(5'd8);
    mem[11] = i_alu(4'h3, 5'd9, 5'd6, 5'd7);
    mem[12] = i_out(5'd9);
    mem[13] = i_const(5'd10, 8'hFF);
    mem[14] = i_alu(4'hA, 5'd11, 5'd10, 5'd1);
    mem[15] = i_out(5'd11);
    mem[16] = i_alu(4'hC, 5'd12, 5'd10, 5'd1);
    mem[17] = i_out(5'd12);
    mem[18] = i_alu(4'h1, 5'd13, 5'd1, 5'd10);
    mem[19] = i_out(5'd13);
    mem[20] = i_alu(4'h5, 5'd14, 5'd10, 5'd1);
    mem[21] = i_out(5'd14);
    mem[22] = i_jmp(8'h00);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hF800);
    exp_q.push_back(16'h0800);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'hFFFE);
    release_reset();
    wait_halt("t5", 200);
    check("t5_imem_addr", {24'd0, imem_addr}, 32'd22);

    // ---- Test 6: backward jump wraps pc ----
    hold_reset();
    clear_mem();
    mem[0] = i_jmp(8'hFF);
    release_reset();
    wait_halt("t6", 30);
    check("t6_wrap_addr", {24'd0, imem_addr}, 32'd255);

    // ---- Test 7: reset during stalled OUT, then clean restart ----
    hold_reset();
    clear_mem();
    mem[0] = i_const(5'd1, 8'h5A);
    mem[1] = i_out(5'd1);
    mem[2] = i_jmp(8'h00);
    out_ready = 1'b0;
    release_reset();
    repeat (8) @(negedge clk);
    #1;
    check("t7_stalled", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
    mem[0] = i_out(5'd1);
    mem[1] = i_jmp(8'h00);
    @(negedge clk);
    #1;
    check("t7_out_valid", {31'd0, out_valid}, 32'd0);
    check("t7_out_data", {16'd0, out_data}, 32'd0);
    check("t7_imem_addr", {24'd0, imem_addr}, 32'd0);
    check("t7_halted", {31'd0, halted}, 32'd0);
    exp_q.push_back(16'h0000);
    out_ready = 1'b1;
    @(negedge clk);
    release_reset();
    wait_halt("t7", 30);
    check("t7_final_addr", {24'd0, imem_addr}, 32'd1);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
